sbox_sched: RTL and testbench
=============================

# sbox_sched

Time-multiplexed scheduler that shares a small bank of AES S-box lookup instances between the two consumers in the AES core. The consumers are the round datapath's SubBytes step (128-bit state) and the key expansion's SubWord step (32-bit word). It arbitrates between the two requesters, sequences each job through the shared S-boxes a chunk of bytes per cycle, and registers the substituted result with a one-cycle done pulse. It instantiates the team's `SBox` lookup module NSBOX times.

## Interface
- NSBOX, 4, number of shared `SBox` instances (bytes substituted per cycle); legal values 1, 2, 4; any other value is an elaboration error
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- st_req  in  1  SubBytes job request; held high with st_in stable until st_gnt
- st_in  in  128  state to substitute; byte b = bits [8b+7:8b]
- st_gnt  out  1  one-cycle pulse; st_in captured at this edge
- st_done  out  1  one-cycle pulse; st_out valid
- st_out  out  128  substituted state, held until next state job completes
- kw_req  in  1  SubWord job request; same rules as st_req
- kw_in  in  32  word to substitute; byte b = bits [8b+7:8b]
- kw_gnt  out  1  one-cycle grant pulse
- kw_done  out  1  one-cycle pulse; kw_out valid
- kw_out  out  32  substituted word, held until next key job completes
- busy  out  1  high while a job is in RUN_ST or RUN_KW

## Operation
- FSM states: IDLE, RUN_ST, RUN_KW. Chunk counter idx counts from 0 to K-1.
- K for a state job = 16/NSBOX. K for a key job = 4/NSBOX.
- IDLE with exactly one req high: grant that requester.
  - Next state is RUN_ST or RUN_KW.
  - idx <= 0.
  - The input is captured into a working register.
- IDLE with both reqs high: grant the requester not granted last.
  - last_grant is updated on every grant.
  - last_grant resets to KW, so the state requester wins the first tie.
- RUN_*, each cycle:
  - Bytes [NSBOX*idx .. NSBOX*idx+NSBOX-1] of the working register pass through the S-boxes.
  - Results are written to the same byte lanes of the result register.
  - idx increments.
- At the edge that writes chunk K-1:
  - The result is copied to st_out or kw_out.
  - The matching done pulses high the next cycle.
  - The FSM returns to IDLE.
- Requests arriving during RUN_* wait; they are not lost while held.
- gnt and done are registered outputs. No combinational path exists from req to gnt.
- The S-box bank is idle in IDLE. Its inputs are driven from the working register only.
- Reset (async, any time, including mid-job):
  - FSM goes to IDLE, idx=0, last_grant=KW.
  - st_gnt, kw_gnt, st_done, kw_done and busy go to 0.
  - st_out and kw_out go to 0.
  - An aborted job produces no done. The requester must re-request after reset.

## Timing
- The grant edge is E0. The gnt pulse is high in the cycle after E0 (busy is also high then).
- The done pulse is high in the cycle after edge E_K. Latency from grant edge to done-high cycle is K cycles.
  - NSBOX=4: state job 4 cycles, key job 1 cycle.
  - NSBOX=1: state job 16 cycles, key job 4 cycles.
- In the done cycle the FSM is already in IDLE. A new grant can occur at the edge ending the done cycle.
  - Back-to-back throughput is therefore K+1 cycles per job.
- A requester that sees gnt must drop req, or present the next job's data, by the edge ending the gnt cycle.
  - The FSM is in RUN_* during that cycle, so a still-high req is treated as a new job only after done.
- st_done and kw_done are never high in the same cycle.
- st_gnt and kw_gnt are never high in the same cycle.

## Test plan
- NSBOX=4, reset then st_req with st_in=128'h0f0e0d0c0b0a09080706050403020100:
  - st_gnt fires 1 cycle after req.
  - st_done fires 4 cycles later.
  - st_out = 128'h76abd7fe2b670130c56f6bf27b777c63.
- NSBOX=4, kw_req with kw_in=32'hcf4f3c09: kw_done 1 cycle after grant, kw_out=32'h8a84eb01.
- Contention after reset (st_req and kw_req high in the same cycle):
  - State is granted first.
  - kw_gnt is granted at the edge ending the st_done cycle.
  - The next tie goes to st.
  - Both results are correct.
- NSBOX=1, state job of all 8'h53 bytes: st_done exactly 16 cycles after the grant edge, st_out all bytes 8'hed.
- rst_n pulsed low mid-job (idx=2):
  - All outputs read 0 immediately, asynchronously.
  - No st_done follows.
  - A re-request completes normally with the correct value.
- Back-to-back state jobs with st_req held high and new data presented after gnt:
  - Grants are spaced K+1 cycles apart.
  - st_out holds the first result until the second done.

Source files
------------

// File: rtl/sbox_sched.sv
// Shared AES S-box bank time-multiplexed between SubBytes (128-bit state) and
// SubWord (32-bit key word) jobs; NSBOX bytes are substituted per cycle.

module SBox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Multiplicative inverse as x^254 in GF(2^8); maps 0 to 0.
  always_comb begin
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module sbox_sched #(
  parameter int unsigned NSBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_gnt,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         busy
);

  if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
    $error("sbox_sched: NSBOX must be 1, 2 or 4");
  end

  localparam int unsigned KSt   = 16 / NSBOX;
  localparam int unsigned KKw   = 4 / NSBOX;
  localparam int unsigned Log2N = (NSBOX == 4) ? 2 : (NSBOX == 2) ? 1 : 0;
  localparam logic [3:0]  LastSt = 4'(KSt - 1);
  localparam logic [3:0]  LastKw = 4'(KKw - 1);

  typedef enum logic [1:0] {StIdle, StRunSt, StRunKw} state_e;

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         last_kw_q, last_kw_d;
  logic [127:0] work_q, work_d;
  logic [127:0] res_q, res_d, res_merge;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         st_gnt_q, st_gnt_d, kw_gnt_q, kw_gnt_d;
  logic         st_done_q, st_done_d, kw_done_q, kw_done_d;

  logic [3:0]   lane   [NSBOX];
  logic [7:0]   sb_in  [NSBOX];
  logic [7:0]   sb_out [NSBOX];

  assign busy = (state_q != StIdle);

  for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
    assign lane[g]  = 4'(idx_q << Log2N) | 4'(g);
    // Bank inputs held at zero in IDLE so the lookups do not toggle.
    assign sb_in[g] = busy ? work_q[{lane[g], 3'b000} +: 8] : 8'h00;
    SBox u_sbox (
      .x (sb_in[g]),
      .y (sb_out[g])
    );
  end

  always_comb begin
    res_merge = res_q;
    for (int i = 0; i < NSBOX; i++) begin
      res_merge[{lane[i], 3'b000} +: 8] = sb_out[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_kw_d = last_kw_q;
    work_d    = work_q;
    res_d     = res_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_gnt_d  = 1'b0;
    kw_gnt_d  = 1'b0;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie, the requester that did not win last time gets the bank.
        if (st_req && (!kw_req || last_kw_q)) begin
          state_d   = StRunSt;
          idx_d     = '0;
          work_d    = st_in;
          st_gnt_d  = 1'b1;
          last_kw_d = 1'b0;
        end else if (kw_req) begin
          state_d   = StRunKw;
          idx_d     = '0;
          work_d    = {96'h0, kw_in};
          kw_gnt_d  = 1'b1;
          last_kw_d = 1'b1;
        end
      end
      StRunSt: begin
        res_d = res_merge;
        idx_d = idx_q + 4'd1;
        if (idx_q == LastSt) begin
          st_out_d  = res_merge;
          st_done_d = 1'b1;
          state_d   = StIdle;
          idx_d     = '0;
        end
      end
      StRunKw: begin
        res_d = res_merge;
        idx_d = idx_q + 4'd1;
        if (idx_q == LastKw) begin
          kw_out_d  = res_merge[31:0];
          kw_done_d = 1'b1;
          state_d   = StIdle;
          idx_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_kw_q <= 1'b1;
      work_q    <= '0;
      res_q     <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_gnt_q  <= 1'b0;
      kw_gnt_q  <= 1'b0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_kw_q <= last_kw_d;
      work_q    <= work_d;
      res_q     <= res_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_gnt_q  <= st_gnt_d;
      kw_gnt_q  <= kw_gnt_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
    end
  end

  assign st_gnt  = st_gnt_q;
  assign kw_gnt  = kw_gnt_q;
  assign st_done = st_done_q;
  assign kw_done = kw_done_q;
  assign st_out  = st_out_q;
  assign kw_out  = kw_out_q;

endmodule

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched: NSBOX=4 instance under randomized traffic,
// plus an NSBOX=1 instance for latency of the narrow bank.

module tb_sbox_sched;

  localparam int KSt4 = 4;
  localparam int KKw4 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         st_req = 1'b0, kw_req = 1'b0;
  logic [127:0] st_in = '0;
  logic [31:0]  kw_in = '0;
  logic         st_gnt, st_done, kw_gnt, kw_done, busy;
  logic [127:0] st_out;
  logic [31:0]  kw_out;

  logic         o_st_req = 1'b0, o_kw_req = 1'b0;
  logic [127:0] o_st_in = '0;
  logic [31:0]  o_kw_in = '0;
  logic         o_st_gnt, o_st_done, o_kw_gnt, o_kw_done, o_busy;
  logic [127:0] o_st_out;
  logic [31:0]  o_kw_out;

  sbox_sched #(.NSBOX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req), .st_in(st_in), .st_gnt(st_gnt), .st_done(st_done), .st_out(st_out),
    .kw_req(kw_req), .kw_in(kw_in), .kw_gnt(kw_gnt), .kw_done(kw_done), .kw_out(kw_out),
    .busy(busy)
  );

  sbox_sched #(.NSBOX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .st_req(o_st_req), .st_in(o_st_in), .st_gnt(o_st_gnt), .st_done(o_st_done),
    .st_out(o_st_out),
    .kw_req(o_kw_req), .kw_in(o_kw_in), .kw_gnt(o_kw_gnt), .kw_done(o_kw_done),
    .kw_out(o_kw_out),
    .busy(o_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference S-box generated from the log/antilog walk over GF(2^8).
  logic [7:0] sbox_tbl [256];

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  function automatic logic [127:0] sub(input logic [127:0] d, input int nbytes);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < nbytes; b++) r[8*b +: 8] = sbox_tbl[d[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    bit           kw;
    logic [127:0] exp;
    int           gcyc;
  } job_t;

  job_t         sb_q[$];
  job_t         mj;
  logic [127:0] st_hold = '0;
  logic [31:0]  kw_hold = '0;

  // Monitor: compares every done against the oldest granted job.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_exclusive", st_gnt & kw_gnt, 0);
      check("done_exclusive", st_done & kw_done, 0);
      if (st_done || kw_done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", {st_done, kw_done}, 0);
        end else begin
          mj = sb_q.pop_front();
          check("done_kind", kw_done, mj.kw);
          check("done_latency", cyc - mj.gcyc, mj.kw ? KKw4 : KSt4);
          if (mj.kw) begin
            check("kw_out", kw_out, mj.exp[31:0]);
            kw_hold = mj.exp[31:0];
          end else begin
            check("st_out", st_out, mj.exp);
            st_hold = mj.exp;
          end
        end
      end else begin
        check("st_out_hold", st_out, st_hold);
        check("kw_out_hold", kw_out, kw_hold);
      end
    end
  end

  // Raise a request, wait for its grant, log the expected result, drop the request.
  task automatic issue(input bit kw, input logic [127:0] d, input logic [127:0] exp,
                       output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    if (kw) begin
      kw_req = 1'b1;
      kw_in  = d[31:0];
    end else begin
      st_req = 1'b1;
      st_in  = d;
    end
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (kw ? kw_gnt : st_gnt) begin
        got  = 1'b1;
        gcyc = cyc;
        sb_q.push_back(job_t'{kw, exp, cyc});
        check("busy_in_gnt_cycle", busy, 1);
      end
    end
    check(kw ? "kw_gnt_seen" : "st_gnt_seen", got, 1);
    @(posedge clk);
    #1;
    if (kw) kw_req = 1'b0;
    else st_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check("queue_drained", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input bit kw, input logic [127:0] d, input logic [127:0] exp,
                      input int klen);
    int  g, dc;
    bit  got;
    got = 1'b0;
    g   = -1;
    dc  = -1;
    if (kw) begin
      o_kw_req = 1'b1;
      o_kw_in  = d[31:0];
    end else begin
      o_st_req = 1'b1;
      o_st_in  = d;
    end
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (kw ? o_kw_gnt : o_st_gnt) begin
        got = 1'b1;
        g   = cyc;
        check("n1_busy", o_busy, 1);
      end
    end
    check("n1_gnt_seen", got, 1);
    @(posedge clk);
    #1;
    o_kw_req = 1'b0;
    o_st_req = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (kw ? o_kw_done : o_st_done) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    check("n1_done_seen", got, 1);
    check("n1_latency", dc - g, klen);
    if (kw) check("n1_kw_out", o_kw_out, exp[31:0]);
    else check("n1_st_out", o_st_out, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
    $fatal(1);
  end

  int gs, gk, g1, g2, c0, mode;
  logic [127:0] r1, r2;

  initial begin
    build_sbox();
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_st_gnt", st_gnt, 0);
    check("rst_kw_gnt", kw_gnt, 0);
    check("rst_st_done", st_done, 0);
    check("rst_kw_done", kw_done, 0);
    check("rst_busy", busy, 0);
    check("rst_st_out", st_out, 0);
    check("rst_kw_out", kw_out, 0);
    @(posedge clk);
    #1;

    // First tie after reset goes to the state requester.
    c0 = cyc;
    fork
      issue(1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
            128'h76abd7fe2b670130c56f6bf27b777c63, gs);
      issue(1'b1, 128'hcf4f3c09, 128'h8a84eb01, gk);
    join
    check("st_gnt_one_cycle", gs - c0, 1);
    check("tie1_kw_after_st", gk - gs, KSt4 + 1);
    wait_drain();

    r1 = rnd128();
    r2 = rnd128();
    fork
      issue(1'b0, r1, sub(r1, 16), gs);
      issue(1'b1, r2, sub(r2, 4), gk);
    join
    check("tie2_st_first", gk - gs, KSt4 + 1);
    wait_drain();

    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      r1 = rnd128();
      r2 = rnd128();
      if (mode == 0) issue(1'b0, r1, sub(r1, 16), gs);
      else if (mode == 1) issue(1'b1, r2, sub(r2, 4), gk);
      else begin
        fork
          issue(1'b0, r1, sub(r1, 16), gs);
          issue(1'b1, r2, sub(r2, 4), gk);
        join
      end
      wait_drain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Back-to-back state jobs with req held high across the grant.
    r1 = rnd128();
    r2 = rnd128();
    issue(1'b0, r1, sub(r1, 16), g1);
    issue(1'b0, r2, sub(r2, 16), g2);
    check("b2b_spacing", g2 - g1, KSt4 + 1);
    wait_drain();

    // Asynchronous reset in the idx=2 cycle of a state job.
    r1 = rnd128();
    issue(1'b0, r1, sub(r1, 16), g1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_st_gnt", st_gnt, 0);
    check("arst_kw_gnt", kw_gnt, 0);
    check("arst_st_done", st_done, 0);
    check("arst_kw_done", kw_done, 0);
    check("arst_busy", busy, 0);
    check("arst_st_out", st_out, 0);
    check("arst_kw_out", kw_out, 0);
    sb_q.delete();
    st_hold = '0;
    kw_hold = '0;
    #10 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    issue(1'b0, r1, sub(r1, 16), g1);
    wait_drain();

    // Single-S-box instance.
    run1(1'b0, {16{8'h53}}, {16{8'hed}}, 16);
    r1 = rnd128();
    run1(1'b1, r1, sub(r1, 4), 4);
    r2 = rnd128();
    run1(1'b0, r2, sub(r2, 16), 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
